mem_arbiter: RTL and testbench

- Sequences the single byte-wide RAM port and shares it between two requesters: instruction fetch (always 4-byte read) and the store/load buffer (1/2/4-byte read or write).
- Accepts at most one request at a time and performs it as a byte-serial transfer, lowest byte first.
- Returns the assembled, size-extended word with a one-cycle finish pulse.
- Honours the ROB exception flush.

---
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IQ)
// and the store/load buffer (SLB). Transfers are byte-serial, lowest byte first.
// Ports: clk, rst (async, active-high); IQ/SLB request inputs; ROB flush;
// RAM byte port (addr/data/we, 1-cycle read latency); per-owner finish pulses
// and returned words.
// Option: define MEM_ARB_RR_EN for round-robin arbitration on contention;
// undefined gives fixed priority, SLB over IQ.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_req_from_iq,
  input  logic [AddrWidth-1:0] addr_from_iq,
  input  logic                 is_req_from_slb,
  input  logic                 is_store_from_slb,
  input  logic [1:0]           size_from_slb,
  input  logic                 is_signed_from_slb,
  input  logic [AddrWidth-1:0] addr_from_slb,
  input  logic [DataWidth-1:0] data_from_slb,
  input  logic                 is_exception_from_rob,
  input  logic [7:0]           data_from_ram,
  output logic [AddrWidth-1:0] addr_to_ram,
  output logic [7:0]           data_to_ram,
  output logic                 is_store_to_ram,
  output logic                 is_finish_to_iq,
  output logic                 is_finish_to_slb,
  output logic [DataWidth-1:0] data_to_iq,
  output logic [DataWidth-1:0] data_to_slb
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e               state_q, state_d;
  logic                 owner_slb_q;
  logic [AddrWidth-1:0] addr_q;
  logic [2:0]           n_q;
  logic [2:0]           cnt_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 sgn_q;
  logic [DataWidth-1:0] asm_q, asm_d;
  logic [DataWidth-1:0] iq_data_q;
  logic [DataWidth-1:0] slb_data_q;
  logic [DataWidth-1:0] ext;
  logic [1:0]           cap_idx;
  logic                 grant, grant_slb;
  logic [2:0]           n_req;
  logic                 last_rd, last_wr;
  logic                 flush;

`ifdef MEM_ARB_RR_EN
  logic                 last_slb_q;
`endif

  assign flush = is_exception_from_rob;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (is_req_from_slb && is_req_from_iq) grant_slb = ~last_slb_q;
    else                                   grant_slb = is_req_from_slb;
`else
    grant_slb = is_req_from_slb;
`endif
  end

  assign grant = (state_q == IDLE) && !flush &&
                 (is_req_from_slb || is_req_from_iq);

  always_comb begin
    n_req = 3'd4;
    if (grant_slb) begin
      unique case (size_from_slb)
        2'b00:   n_req = 3'd1;
        2'b01:   n_req = 3'd2;
        default: n_req = 3'd4;
      endcase
    end
  end

  // cnt_q is the cycle index inside READ/WRITE; a read captures byte
  // cnt_q-1 because the RAM answers one cycle after the address.
  assign last_rd = (cnt_q == n_q);
  assign last_wr = (cnt_q == n_q - 3'd1);
  assign cap_idx = 2'(cnt_q - 3'd1);

  always_comb begin
    asm_d = asm_q;
    asm_d[{cap_idx, 3'b000} +: 8] = data_from_ram;
  end

  always_comb begin
    unique case (n_q)
      3'd1:    ext = {{(DataWidth-8){sgn_q & asm_d[7]}}, asm_d[7:0]};
      3'd2:    ext = {{(DataWidth-16){sgn_q & asm_d[15]}}, asm_d[15:0]};
      default: ext = asm_d;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant)
          state_d = (grant_slb && is_store_from_slb) ? WRITE : READ;
      end
      READ: begin
        if (flush)        state_d = IDLE;
        else if (last_rd) state_d = DONE;
      end
      WRITE: begin
        if (last_wr) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    is_store_to_ram  = 1'b0;
    data_to_ram      = 8'h00;
    is_finish_to_iq  = 1'b0;
    is_finish_to_slb = 1'b0;
    unique case (state_q)
      WRITE: begin
        is_store_to_ram = 1'b1;
        data_to_ram     = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
      DONE: begin
        is_finish_to_iq  = ~owner_slb_q;
        is_finish_to_slb = owner_slb_q;
      end
      default: ;
    endcase
  end

  assign addr_to_ram = addr_q;
  assign data_to_iq  = iq_data_q;
  assign data_to_slb = slb_data_q;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_slb_q <= 1'b0;
      addr_q      <= '0;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= '0;
      sgn_q       <= 1'b0;
      asm_q       <= '0;
      iq_data_q   <= '0;
      slb_data_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_slb_q  <= 1'b0;
`endif
    end else if (grant) begin
      owner_slb_q <= grant_slb;
      addr_q      <= grant_slb ? addr_from_slb : addr_from_iq;
      n_q         <= n_req;
      cnt_q       <= 3'd0;
      wdata_q     <= data_from_slb;
      sgn_q       <= grant_slb & is_signed_from_slb;
`ifdef MEM_ARB_RR_EN
      last_slb_q  <= grant_slb;
`endif
    end else if (state_q == READ) begin
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q < n_q - 3'd1) addr_q <= addr_q + AddrWidth'(1);
      if (cnt_q != 3'd0)      asm_q  <= asm_d;
      if (last_rd && !flush) begin
        if (owner_slb_q) slb_data_q <= ext;
        else             iq_data_q  <= ext;
      end
    end else if (state_q == WRITE) begin
      cnt_q <= cnt_q + 3'd1;
      if (!last_wr) addr_q <= addr_q + AddrWidth'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a
// behavioural RAM and a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_req_from_iq;
  logic [31:0] addr_from_iq;
  logic        is_req_from_slb;
  logic        is_store_from_slb;
  logic [1:0]  size_from_slb;
  logic        is_signed_from_slb;
  logic [31:0] addr_from_slb;
  logic [31:0] data_from_slb;
  logic        is_exception_from_rob;
  logic [7:0]  data_from_ram = 8'h00;
  logic [31:0] addr_to_ram;
  logic [7:0]  data_to_ram;
  logic        is_store_to_ram;
  logic        is_finish_to_iq;
  logic        is_finish_to_slb;
  logic [31:0] data_to_iq;
  logic [31:0] data_to_slb;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_req_from_iq        (is_req_from_iq),
    .addr_from_iq          (addr_from_iq),
    .is_req_from_slb       (is_req_from_slb),
    .is_store_from_slb     (is_store_from_slb),
    .size_from_slb         (size_from_slb),
    .is_signed_from_slb    (is_signed_from_slb),
    .addr_from_slb         (addr_from_slb),
    .data_from_slb         (data_from_slb),
    .is_exception_from_rob (is_exception_from_rob),
    .data_from_ram         (data_from_ram),
    .addr_to_ram           (addr_to_ram),
    .data_to_ram           (data_to_ram),
    .is_store_to_ram       (is_store_to_ram),
    .is_finish_to_iq       (is_finish_to_iq),
    .is_finish_to_slb      (is_finish_to_slb),
    .data_to_iq            (data_to_iq),
    .data_to_slb           (data_to_slb)
  );

  bit [7:0] mem [bit [31:0]];

  function automatic bit [7:0] rd(bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (is_store_to_ram) mem[addr_to_ram] = data_to_ram;
    data_from_ram <= rd(addr_to_ram);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  bit        m_last_slb = 1'b0;
  bit [31:0] m_iq  = '0;
  bit [31:0] m_slb = '0;
  bit        m_slb_ok = 1'b1;

  task automatic drop_reqs();
    is_req_from_iq  = 1'b0;
    is_req_from_slb = 1'b0;
  endtask

  // Starts at the negedge of an idle cycle; returns at the negedge of the
  // following idle cycle.
  task automatic txn(input bit riq, input bit rslb, input bit st,
                     input bit [1:0] sz, input bit sgn,
                     input bit [31:0] aiq, input bit [31:0] aslb,
                     input bit [31:0] dslb, input int fl);
    bit        own_slb, wr, abort;
    int        n, fin_exp, fin_at, other, nst, lim;
    bit [31:0] a, exp;
    bit [7:0]  after;
    bit [31:0] s_addr [16];
    bit [7:0]  s_dat  [16];
`ifdef MEM_ARB_RR_EN
    own_slb = (riq && rslb) ? !m_last_slb : rslb;
`else
    own_slb = rslb;
`endif
    m_last_slb = own_slb;
    n  = !own_slb ? 4 : (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    a  = own_slb ? aslb : aiq;
    wr = own_slb && st;
    exp = 0;
    for (int i = 0; i < n; i++) exp |= 32'(rd(a + 32'(i))) << (8 * i);
    if (own_slb && sgn && n < 4 && exp[8*n-1])
      exp |= ~((32'd1 << (8 * n)) - 32'd1);
    after   = rd(a + 32'(n));
    abort   = !wr && fl >= 1 && fl <= n + 1;
    fin_exp = abort ? -1 : (wr ? n + 1 : n + 2);

    is_req_from_iq     = riq;
    addr_from_iq       = aiq;
    is_req_from_slb    = rslb;
    is_store_from_slb  = st;
    size_from_slb      = sz;
    is_signed_from_slb = sgn;
    addr_from_slb      = aslb;
    data_from_slb      = dslb;
    fin_at = -1; other = 0; nst = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      s_addr[c] = addr_to_ram;
      s_dat[c]  = data_to_ram;
      nst += int'(is_store_to_ram);
      if (own_slb ? is_finish_to_iq : is_finish_to_slb) other++;
      if ((own_slb ? is_finish_to_slb : is_finish_to_iq) && fin_at < 0)
        fin_at = c;
      is_exception_from_rob = (c == fl);
      if (c == fl && abort) drop_reqs();
      if (fin_at > 0) begin
        drop_reqs();
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    is_exception_from_rob = 1'b0;
    check("fin_once", {30'd0, is_finish_to_iq, is_finish_to_slb}, 32'd0);
    check("fin_cycle", 32'(fin_at), 32'(fin_exp));
    check("other_fin", 32'(other), 32'd0);
    check("store_cnt", 32'(nst), wr ? 32'(n) : 32'd0);
    lim = abort ? fl : n;
    for (int k = 0; k < lim; k++) begin
      check("addr", s_addr[k+1], a + 32'(k));
      if (wr) check("wbyte", 32'(s_dat[k+1]), 32'(dslb[8*k +: 8]));
    end
    if (wr) begin
      for (int k = 0; k < n; k++)
        check("ram", 32'(rd(a + 32'(k))), 32'(dslb[8*k +: 8]));
      check("ram_next", 32'(rd(a + 32'(n))), 32'(after));
      m_slb_ok = 1'b0;
    end else if (!abort) begin
      if (own_slb) begin
        m_slb = exp;
        m_slb_ok = 1'b1;
      end else begin
        m_iq = exp;
      end
    end
    check("iq_data", data_to_iq, m_iq);
    if (m_slb_ok) check("slb_data", data_to_slb, m_slb);
  endtask

  initial begin
    bit riq, rslb;
    bit [31:0] a;
    int fl;
    rst = 1'b1;
    drop_reqs();
    addr_from_iq = '0; addr_from_slb = '0; data_from_slb = '0;
    is_store_from_slb = 1'b0; size_from_slb = 2'b00;
    is_signed_from_slb = 1'b0; is_exception_from_rob = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {addr_to_ram[23:0], data_to_ram} |
          {27'd0, is_store_to_ram, is_finish_to_iq, is_finish_to_slb, 2'd0},
          32'd0);
    check("rst_data", data_to_iq | data_to_slb, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h00;
    mem[32'h1002] = 8'hA0; mem[32'h1003] = 8'h93;
    mem[32'h0010] = 8'h80;

    txn(1, 0, 0, 2'b00, 0, 32'h1000, 0, 0, 0);
    check("fetch_word", data_to_iq, 32'h93A00013);
    txn(0, 1, 1, 2'b01, 0, 0, 32'h2000, 32'hDEADBEEF, 0);
    txn(0, 1, 0, 2'b00, 1, 0, 32'h10, 0, 0);
    check("lb_signed", data_to_slb, 32'hFFFFFF80);
    txn(0, 1, 0, 2'b00, 0, 0, 32'h10, 0, 0);
    check("lb_unsigned", data_to_slb, 32'h00000080);
    repeat (3) txn(1, 1, 0, 2'b10, 0, 32'h1000, 32'h3000, 0, 0);
    txn(1, 0, 0, 2'b00, 0, 32'h1100, 0, 0, 3);
    txn(1, 0, 0, 2'b00, 0, 32'h1000, 0, 0, 0);
    txn(0, 1, 1, 2'b10, 0, 0, 32'h2400, 32'h12345678, 2);

    // asynchronous reset in the middle of a fetch
    is_req_from_iq = 1'b1;
    addr_from_iq   = 32'h1200;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_outs", {addr_to_ram[23:0], data_to_ram} |
          {27'd0, is_store_to_ram, is_finish_to_iq, is_finish_to_slb, 2'd0},
          32'd0);
    check("arst_data", data_to_iq | data_to_slb, 32'd0);
    drop_reqs();
    @(posedge clk);
    #3 rst = 1'b0;
    m_last_slb = 1'b0; m_iq = '0; m_slb = '0; m_slb_ok = 1'b1;
    @(negedge clk);
    txn(1, 1, 0, 2'b01, 1, 32'h1000, 32'h0F, 0, 0);
    txn(1, 1, 0, 2'b10, 0, 32'h1000, 32'h20, 0, 0);

    for (int i = 0; i < 40; i++) begin
      riq  = 1'($urandom);
      rslb = 1'($urandom);
      if (!riq && !rslb) rslb = 1'b1;
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      a  = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFD + $urandom_range(0, 2)
                                       : $urandom;
      txn(riq, rslb, 1'($urandom), 2'($urandom), 1'($urandom),
          $urandom, a, $urandom, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
